comm_tx_arbiter: RTL and testbench

Shares the single communications serial transmitter (start/data in, busy out) between NREQ byte-wide requesters, e.g. the J1 CPU I/O port and a hardware message source. Round-robin arbitration. The block sequences each transfer through a start pulse, waits for the busy flag to rise and then fall, and enforces an inter-byte guard time. It sits in the j1soc top level between the requesters and the transmitter that drives c_tx/c_bussy.

---
 rtl/comm_pkg.sv | 32 +++
 rtl/comm_rr_picker.sv | 31 +++
 rtl/comm_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_comm_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and helpers for the communications transmitter sharing logic.
package comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } comm_state_t;

    localparam int COMM_DW = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        int w;
        w = clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/comm_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module comm_rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    // Scan last+1, last+2, ... mod NREQ and keep the first requester found.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comm_tx_arbiter.sv
// Round-robin sharing of the single serial transmitter between NREQ byte
// requesters, with start/busy handshake, busy-rise timeout and guard gap.
module comm_tx_arbiter
    import comm_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DW           = COMM_DW,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ*DW-1:0] data_i,
    output logic [NREQ-1:0]  ack_o,
    output logic [NREQ-1:0]  grant_o,
    output logic             tx_start_o,
    output logic [DW-1:0]    tx_data_o,
    input  logic             tx_busy_i,
    output logic             err_o,
    input  logic             err_clr_i,
    output logic             idle_o
);

    localparam int IW = cnt_width(NREQ - 1);
    localparam int TW = cnt_width(BUSY_TIMEOUT);
    localparam int GW = cnt_width(GAP_CYCLES);

    comm_state_t     state;
    logic [IW-1:0]   last;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    comm_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req    (req_i),
        .last   (last),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Transfer sequencer: arbitrate, pulse start, track busy, hold off for the gap.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state      <= ST_IDLE;
            last       <= IW'(NREQ - 1);
            tcnt       <= '0;
            gcnt       <= '0;
            ack_o      <= '0;
            grant_o    <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            err_o      <= 1'b0;
            idle_o     <= 1'b1;
        end else begin
            ack_o      <= '0;
            tx_start_o <= 1'b0;
            // A timeout in this same cycle overrides the clear below.
            if (err_clr_i) begin
                err_o <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!tx_busy_i && pick_valid) begin
                        tx_data_o  <= data_i[pick_idx*DW +: DW];
                        grant_o    <= pick_onehot;
                        ack_o      <= pick_onehot;
                        tx_start_o <= 1'b1;
                        last       <= pick_idx;
                        tcnt       <= '0;
                        idle_o     <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_busy_i) begin
                        state <= ST_BUSY;
                    end else if (int'(tcnt) + 1 >= BUSY_TIMEOUT) begin
                        // Pointer stays on the failed owner so it drops to lowest priority.
                        err_o   <= 1'b1;
                        grant_o <= '0;
                        idle_o  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_BUSY: begin
                    if (!tx_busy_i) begin
                        if (GAP_CYCLES == 0) begin
                            grant_o <= '0;
                            idle_o  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            gcnt  <= '0;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (int'(gcnt) + 1 >= GAP_CYCLES) begin
                        grant_o <= '0;
                        idle_o  <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_tx_arbiter.sv
// Directed bench for comm_tx_arbiter with a simple transmitter busy model.
module tb_comm_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  ack;
    logic [1:0]  grant;
    logic        start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic        idle;

    logic        model_busy;
    logic        force_busy;
    logic        model_never;
    int          busy_len;
    int          dly;
    int          hold;

    int          n_cmp;
    int          n_err;

    assign busy = model_busy | force_busy;

    comm_tx_arbiter #(
        .NREQ         (2),
        .DW           (8),
        .BUSY_TIMEOUT (16),
        .GAP_CYCLES   (4)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (rst),
        .req_i      (req),
        .data_i     (data),
        .ack_o      (ack),
        .grant_o    (grant),
        .tx_start_o (start),
        .tx_data_o  (tx_data),
        .tx_busy_i  (busy),
        .err_o      (err),
        .err_clr_i  (err_clr),
        .idle_o     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises two cycles after a start pulse, holds busy_len cycles.
    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            dly        = 0;
            hold       = 0;
        end else if (model_busy) begin
            if (hold > 0) hold--;
            if (hold == 0) model_busy = 1'b0;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                model_busy = 1'b1;
                hold       = busy_len;
            end
        end else if (start && !model_never) begin
            dly = 2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while (ack == 2'b00 && g < 300);
        chk(tag, 32'(g >= 300), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while (!idle && g < 300) begin
            tick();
            g++;
        end
        chk(tag, 32'(g >= 300), 32'd0);
    endtask

    initial begin
        int g;
        int n;
        logic seen;
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        req         = 2'b00;
        data        = 16'h0000;
        err_clr     = 1'b0;
        force_busy  = 1'b0;
        model_never = 1'b0;
        busy_len    = 100;
        repeat (2) tick();
        rst = 1'b0;

        // Reset values
        chk("rst_ack",   32'(ack),     32'h0);
        chk("rst_grant", 32'(grant),   32'h0);
        chk("rst_start", 32'(start),   32'h0);
        chk("rst_data",  32'(tx_data), 32'h0);
        chk("rst_err",   32'(err),     32'h0);
        chk("rst_idle",  32'(idle),    32'h1);

        // Single request, one-cycle latency, busy 100 cycles, 4 gap cycles
        req  = 2'b01;
        data = 16'h00A5;
        tick();
        chk("single_ack",   32'(ack),     32'h1);
        chk("single_start", 32'(start),   32'h1);
        chk("single_grant", 32'(grant),   32'h1);
        chk("single_data",  32'(tx_data), 32'hA5);
        chk("single_idle",  32'(idle),    32'h0);
        req = 2'b00;
        tick();
        chk("single_ack_drop",   32'(ack),   32'h0);
        chk("single_start_drop", 32'(start), 32'h0);
        chk("single_grant_hold", 32'(grant), 32'h1);
        g = 0;
        while (!busy && g < 20) begin tick(); g++; end
        chk("single_busy_rise_wait", 32'(g >= 20), 32'd0);
        g = 0;
        while (busy && g < 200) begin tick(); g++; end
        chk("single_busy_fall_wait", 32'(g >= 200), 32'd0);
        chk("single_data_hold", 32'(tx_data), 32'hA5);
        chk("single_idle_in_gap", 32'(idle), 32'h0);
        n = 0;
        while (!idle && n < 50) begin tick(); n++; end
        chk("single_gap_len",   32'(n),     32'd4);
        chk("single_grant_end", 32'(grant), 32'h0);

        // Contention: fair alternation starting at requester 0 after reset
        do_reset();
        busy_len = 5;
        req  = 2'b11;
        data = 16'h2211;
        for (int i = 0; i < 4; i++) begin
            wait_ack("cont_wait_ack");
            chk("cont_ack",   32'(ack),     (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("cont_grant", 32'(grant),   (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("cont_data",  32'(tx_data), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        req = 2'b00;
        wait_idle("cont_wait_idle");

        // Timeout: busy never rises; last owner was 1 so requester 0 wins
        model_never = 1'b1;
        req  = 2'b11;
        data = 16'h2233;
        wait_ack("to_wait_ack0");
        chk("to_ack0",  32'(ack),     32'h1);
        chk("to_data0", 32'(tx_data), 32'h33);
        req = 2'b10;
        repeat (15) tick();
        chk("to_err_before", 32'(err),  32'h0);
        chk("to_idle_before", 32'(idle), 32'h0);
        tick();
        chk("to_err_set",   32'(err),   32'h1);
        chk("to_idle_back", 32'(idle),  32'h1);
        chk("to_grant_clr", 32'(grant), 32'h0);
        tick();
        chk("to_next_ack",  32'(ack),     32'h2);
        chk("to_next_data", 32'(tx_data), 32'h22);
        req     = 2'b00;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_cleared", 32'(err), 32'h0);
        repeat (14) tick();
        err_clr = 1'b1;
        tick();
        chk("to_set_beats_clr", 32'(err),  32'h1);
        chk("to_idle_again",    32'(idle), 32'h1);
        err_clr = 1'b0;
        tick();
        chk("to_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr2", 32'(err), 32'h0);

        // External busy blocks arbitration in IDLE
        force_busy = 1'b1;
        req  = 2'b01;
        data = 16'h22A5;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (ack != 2'b00 || start) seen = 1'b1;
        end
        chk("xbusy_no_grant", 32'(seen), 32'h0);
        force_busy = 1'b0;
        tick();
        chk("xbusy_ack",   32'(ack),   32'h1);
        chk("xbusy_start", 32'(start), 32'h1);
        chk("xbusy_grant", 32'(grant), 32'h1);
        req        = 2'b00;
        force_busy = 1'b1;
        repeat (3) tick();
        chk("xbusy_in_busy_grant", 32'(grant), 32'h1);

        // Asynchronous reset mid-transfer, then requester 1 pending
        req        = 2'b10;
        force_busy = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant),   32'h0);
        chk("arst_idle",  32'(idle),    32'h1);
        chk("arst_ack",   32'(ack),     32'h0);
        chk("arst_start", 32'(start),   32'h0);
        chk("arst_data",  32'(tx_data), 32'h0);
        chk("arst_err",   32'(err),     32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_ack1",   32'(ack),     32'h2);
        chk("arst_start1", 32'(start),   32'h1);
        chk("arst_grant1", 32'(grant),   32'h2);
        chk("arst_data1",  32'(tx_data), 32'h22);
        req = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
